uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_synchronizer.sv | 21 ++
 rtl/uart_receiver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM states, data-width encoding,
// oversampling constants and a width-to-last-bit-index helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    BITS5 = 2'b00,
    BITS6 = 2'b01,
    BITS7 = 2'b10,
    BITS8 = 2'b11
  } data_bits_e;

  // Index of the final data bit: 5 bits -> 4 ... 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(data_bits_e w);
    return {1'b1, w};
  endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Multi-flop synchronizer for the asynchronous rx line, reset to idle-high.
// Ports: clk_i, rst_n_i, d_i (async in), q_o (synchronized out).
module uart_rx_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver, 5..8 data bits, optional parity, 1/2 stop.
// Ports: clk_i, rst_n_i, sample_i, enable_i, rx_i, config in; data/flags out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sample_i,
  input  logic       enable_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  state_e     state, state_n;
  logic       rx_s;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  data_bits_e cfg_bits;
  logic       cfg_par_en;
  logic       cfg_odd;
  logic       cfg_stop2;
  logic       perr;
  logic       ferr;
  logic       tick_mid;
  logic       tick_end;
  logic       enter;
  logic       take;
  logic       done;

  uart_rx_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  assign tick_mid = sample_i && (tick_cnt == 4'(MID_SAMPLE - 1));
  assign tick_end = sample_i && (tick_cnt == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick_mid) begin
          take    = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_end) begin
          take = 1'b1;
          if (bit_cnt == last_bit_idx(cfg_bits))
            state_n = cfg_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick_end) begin
          take    = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        // bit_cnt counts stop bits here; leave mid-bit on the last one.
        if (tick_end) begin
          take = 1'b1;
          if (bit_cnt[0] == cfg_stop2) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable_i) begin
      state_n = IDLE;
      take    = 1'b0;
      done    = 1'b0;
    end
    enter = (state_n != state);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      cfg_bits       <= BITS8;
      cfg_par_en     <= 1'b0;
      cfg_odd        <= 1'b0;
      cfg_stop2      <= 1'b0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      data_o         <= '0;
      valid_o        <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      if (enter || take || state == IDLE) tick_cnt <= '0;
      else if (sample_i)                  tick_cnt <= tick_cnt + 4'd1;

      if (enter)     bit_cnt <= '0;
      else if (take) bit_cnt <= bit_cnt + 3'd1;

      if (enter && state_n == START) begin
        cfg_bits   <= data_bits_e'(data_bits_i);
        cfg_par_en <= parity_en_i;
        cfg_odd    <= parity_odd_i;
        cfg_stop2  <= stop_bits_i;
        shreg      <= '0;
        perr       <= 1'b0;
        ferr       <= 1'b0;
      end

      if (take && state == DATA)
        shreg[bit_cnt] <= rx_s;
      if (take && state == PARITY)
        perr <= ((^shreg) ^ rx_s) != cfg_odd;
      if (take && state == STOP && !rx_s)
        ferr <= 1'b1;

      valid_o <= done;
      if (done) begin
        data_o         <= shreg;
        parity_error_o <= perr;
        frame_error_o  <= ferr | ~rx_s;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule
